// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment counter: segment patterns and digit range.
// Patterns are ordered {g,f,e,d,c,b,a} with 1 = segment lit.
package seven_segment_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111100;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1100111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

endpackage

// File: rtl/seven_segment_counter_if.sv
// Control and display bundle between firmware-facing logic and the counter.
// master drives configuration and observes the display; slave is the counter.
interface seven_segment_counter_if #(
  parameter int PRESCALE_W = 16
);

  logic                  enable;
  logic                  period_sel;
  logic [PRESCALE_W-1:0] period;
  logic [6:0]            segments;
  logic [6:0]            seg_oeb;
  logic [3:0]            digit;
  logic                  tick;

  modport master (
    output enable, period_sel, period,
    input  segments, seg_oeb, digit, tick
  );

  modport slave (
    input  enable, period_sel, period,
    output segments, seg_oeb, digit, tick
  );

endinterface

// File: rtl/seven_segment_decoder.sv
// Combinational BCD to seven-segment decode; 10-15 decode to blank.
// Output is active-high {g,f,e,d,c,b,a}.
module seven_segment_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  // map each BCD value to its lit-segment pattern
  always_comb begin
    pattern = SEG_BLANK;
    unique case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_segment_counter.sv
// Prescaled decimal counter driving a registered seven-segment display.
// Define COMMON_ANODE_EN for inverted (active-low) segment outputs.
module seven_segment_counter
  import seven_segment_pkg::*;
#(
  parameter int PRESCALE_W     = 16,
  parameter int DEFAULT_PERIOD = 255
) (
  input  logic                          clock,
  input  logic                          resetb,
  seven_segment_counter_if.slave        bus
);

`ifdef COMMON_ANODE_EN
  localparam logic [6:0] SEG_RST = ~SEG_0;
`else
  localparam logic [6:0] SEG_RST = SEG_0;
`endif

  logic [PRESCALE_W-1:0] pres_q, pres_d;
  logic [3:0]            digit_q, digit_d;
  logic                  tick_q, tick_d;
  logic [6:0]            seg_q, seg_d;
  logic [PRESCALE_W-1:0] act_period;
  logic [6:0]            pattern;

  seven_segment_decoder u_dec (
    .bcd     (digit_q),
    .pattern (pattern)
  );

  assign act_period = bus.period_sel ? bus.period
                                     : PRESCALE_W'(DEFAULT_PERIOD);

  // >= compare so a period lowered under the count ticks at once
  always_comb begin
    pres_d  = pres_q;
    digit_d = digit_q;
    tick_d  = 1'b0;
    if (bus.enable) begin
      if (pres_q >= act_period) begin
        pres_d  = '0;
        tick_d  = 1'b1;
        digit_d = (digit_q >= DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        pres_d = pres_q + PRESCALE_W'(1);
      end
    end
  end

  // segment register follows the digit one clock later
  always_comb begin
`ifdef COMMON_ANODE_EN
    seg_d = ~pattern;
`else
    seg_d = pattern;
`endif
  end

  // state and output registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pres_q  <= '0;
      digit_q <= 4'd0;
      tick_q  <= 1'b0;
      seg_q   <= SEG_RST;
    end else begin
      pres_q  <= pres_d;
      digit_q <= digit_d;
      tick_q  <= tick_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.segments = seg_q;
  assign bus.seg_oeb  = 7'b0;
  assign bus.digit    = digit_q;
  assign bus.tick     = tick_q;

endmodule

// File: tb/tb_seven_segment_counter.sv
// Scoreboard bench for seven_segment_counter: expected ticks queued at stimulus.
// Honours COMMON_ANODE_EN for the expected segment polarity.
module tb_seven_segment_counter;

  typedef struct {
    int         cyc;
    logic [3:0] dig;
  } exp_t;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic       seg_pend = 1'b0;
  logic [6:0] seg_exp = '0;
  int   c0;

  seven_segment_counter_if #(.PRESCALE_W(16)) bus ();

  seven_segment_counter #(
    .PRESCALE_W     (16),
    .DEFAULT_PERIOD (255)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] pat(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'b0111111;
      4'd1: p = 7'b0000110;
      4'd2: p = 7'b1011011;
      4'd3: p = 7'b1001111;
      4'd4: p = 7'b1100110;
      4'd5: p = 7'b1101101;
      4'd6: p = 7'b1111100;
      4'd7: p = 7'b0000111;
      4'd8: p = 7'b1111111;
      4'd9: p = 7'b1100111;
      default: p = 7'b0000000;
    endcase
`ifdef COMMON_ANODE_EN
    p = ~p;
`endif
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input int c, input int d);
    exp_t e;
    e.cyc = c;
    e.dig = 4'(d);
    sb.push_back(e);
  endtask

  // one clock: outputs sampled on the falling edge
  task automatic step();
    exp_t e;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    if (seg_pend) begin
      chk("seg", {25'd0, bus.segments}, {25'd0, seg_exp});
      seg_pend = 1'b0;
    end
    if (bus.tick) begin
      if (sb.size() == 0) begin
        chk("tick_unexp", {31'd0, bus.tick}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tick_cyc", cyc, e.cyc);
        chk("tick_dig", {28'd0, bus.digit}, {28'd0, e.dig});
        seg_exp  = pat(e.dig);
        seg_pend = 1'b1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    seg_pend = 1'b0;
    bus.enable = 1'b0;
    run(3);
    resetb = 1'b1;
    step();
  endtask

  initial begin
    bus.enable     = 1'b0;
    bus.period_sel = 1'b0;
    bus.period     = '0;
    resetb         = 1'b0;
    run(3);
    chk("rst_digit", {28'd0, bus.digit}, 32'd0);
    chk("rst_seg", {25'd0, bus.segments}, {25'd0, pat(4'd0)});
    chk("rst_tick", {31'd0, bus.tick}, 32'd0);
    chk("rst_oeb", {25'd0, bus.seg_oeb}, 32'd0);

    // idle after release: nothing moves
    resetb = 1'b1;
    run(1000);
    chk("idle_digit", {28'd0, bus.digit}, 32'd0);
    chk("idle_seg", {25'd0, bus.segments}, {25'd0, pat(4'd0)});
    chk("idle_tick", {31'd0, bus.tick}, 32'd0);

    // default period: tick every 256 clocks, full 0..9 walk and wrap
    c0 = cyc;
    bus.enable = 1'b1;
    for (int k = 1; k <= 11; k++) push(c0 + 256 * k, k % 10);
    run(2560 + 300);
    chk("def_sb_empty", sb.size(), 32'd0);
    chk("def_digit", {28'd0, bus.digit}, 32'd1);

    // asynchronous reset mid-count takes effect without a clock edge
    #2;
    resetb = 1'b0;
    #1;
    chk("arst_digit", {28'd0, bus.digit}, 32'd0);
    chk("arst_seg", {25'd0, bus.segments}, {25'd0, pat(4'd0)});
    chk("arst_tick", {31'd0, bus.tick}, 32'd0);
    @(negedge clock);
    do_reset();

    // period 0: a tick and a new digit on every clock
    bus.period     = 16'd0;
    bus.period_sel = 1'b1;
    c0 = cyc;
    bus.enable = 1'b1;
    for (int k = 1; k <= 11; k++) push(c0 + k, k % 10);
    run(11);
    bus.enable = 1'b0;
    run(3);
    chk("p0_sb_empty", sb.size(), 32'd0);
    chk("p0_tick_off", {31'd0, bus.tick}, 32'd0);
    chk("p0_digit", {28'd0, bus.digit}, 32'd1);
    do_reset();

    // shrink period below the running count
    bus.period = 16'd100;
    c0 = cyc;
    bus.enable = 1'b1;
    run(80);
    bus.period = 16'd10;
    for (int j = 0; j < 4; j++) push(c0 + 81 + 11 * j, j + 1);
    run(1 + 33 + 2);
    bus.enable = 1'b0;
    step();
    chk("shr_sb_empty", sb.size(), 32'd0);
    do_reset();

    // pause at digit 5 then resume the interrupted interval
    bus.period = 16'd20;
    c0 = cyc;
    bus.enable = 1'b1;
    for (int k = 1; k <= 5; k++) push(c0 + 21 * k, k);
    run(110);
    bus.enable = 1'b0;
    run(500);
    chk("pau_digit", {28'd0, bus.digit}, 32'd5);
    chk("pau_seg", {25'd0, bus.segments}, {25'd0, pat(4'd5)});
    chk("pau_tick", {31'd0, bus.tick}, 32'd0);
    chk("pau_sb_empty", sb.size(), 32'd0);
    bus.enable = 1'b1;
    push(c0 + 626, 6);
    push(c0 + 647, 7);
    run(40);
    chk("res_sb_empty", sb.size(), 32'd0);
    chk("res_digit", {28'd0, bus.digit}, 32'd7);
    chk("end_oeb", {25'd0, bus.seg_oeb}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
